mult_seq: RTL

- Iterative shift-add multiplier. It is the clocked, parametrised successor of the team's combinational for-loop multiplier.
- Retires K multiplier bits per cycle (radix 2^K).
- Supports a per-operation signed/unsigned mode.
- Uses valid/ready handshakes on input and output, so it can sit in datapaths where a full combinational N×N array is too large or too slow.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/mult_pp_radix.sv | 18 +
 rtl/mult_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM encoding and
// step/counter sizing helpers derived from the operand width and radix.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of CALC cycles: one per K-bit digit of the multiplier.
   function automatic int unsigned calc_steps(input int unsigned n, input int unsigned k);
      return n / k;
   endfunction

   // Step counter width; a single-step configuration still needs one bit.
   function automatic int unsigned calc_cnt_w(input int unsigned n, input int unsigned k);
      int unsigned s;
      s = n / k;
      return (s > 1) ? $clog2(s) : 1;
   endfunction

endpackage

// File: rtl/mult_pp_radix.sv
// Combinational K-bit x W-bit partial product: K conditional shifted adds.
module mult_pp_radix #(
   parameter int unsigned W = 16,
   parameter int unsigned K = 2
) (
   input  logic [W-1:0] mcand,
   input  logic [K-1:0] digit,
   output logic [W-1:0] pp
);

   always_comb begin
      pp = '0;
      for (int unsigned i = 0; i < K; i++) begin
         if (digit[i]) pp = pp + (mcand << i);
      end
   end

endmodule

// File: rtl/mult_seq.sv
// Iterative radix-2^K shift-add multiplier with valid/ready handshakes and a
// per-operation signed/unsigned mode (sign-magnitude internally).
module mult_seq
   import mult_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned K = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           is_signed,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] out
);

   localparam int unsigned STEPS = calc_steps(N, K);
   localparam int unsigned CW    = calc_cnt_w(N, K);
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_bad_params
      $error("mult_seq: N must be >= 2 and a multiple of K, with 1 <= K <= N");
   end

   state_t          state_q, state_d;
   logic [2*N-1:0]  mcand_q;
   logic [N-1:0]    bsh_q;
   logic [2*N-1:0]  acc_q;
   logic [2*N-1:0]  acc_d;
   logic [2*N-1:0]  pp;
   logic [CW-1:0]   cnt_q;
   logic            neg_q;
   logic [2*N-1:0]  out_q;
   logic [N-1:0]    a_mag;
   logic [N-1:0]    b_mag;

   // |-2^(N-1)| wraps back to 2^(N-1), which is correct read as unsigned.
   assign a_mag = (is_signed && a[N-1]) ? -a : a;
   assign b_mag = (is_signed && b[N-1]) ? -b : b;

   mult_pp_radix #(
      .W (2*N),
      .K (K)
   ) u_pp (
      .mcand (mcand_q),
      .digit (bsh_q[K-1:0]),
      .pp    (pp)
   );

   assign acc_d = acc_q + pp;
   assign out   = out_q;

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = CALC;
         end
         CALC: begin
            if (cnt_q == '0) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mcand_q <= '0;
         bsh_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  mcand_q <= {{N{1'b0}}, a_mag};
                  bsh_q   <= b_mag;
                  neg_q   <= is_signed & (a[N-1] ^ b[N-1]);
                  acc_q   <= '0;
                  cnt_q   <= LAST;
               end
            end
            CALC: begin
               acc_q   <= acc_d;
               mcand_q <= mcand_q << K;
               bsh_q   <= bsh_q >> K;
               cnt_q   <= cnt_q - CW'(1);
               // Final digit: apply the sign to the completed magnitude.
               if (cnt_q == '0) out_q <= neg_q ? -acc_d : acc_d;
            end
            default: ;
         endcase
      end
   end

endmodule
